// File: rtl/bus_dma_reader.sv
// bus_dma_reader: bus initiator that fetches a block of words from RAM into a show-ahead sample FIFO
// Ports: clk50MHz / reset_L  clock and asynchronous active-low reset
//        start, base_addr, word_count  launch a transfer; busy, done, err  transfer status
//        bus_req, bus_ack, bus_ctrl_*, bus_data_*  one BusController master slot
//        sample_data, sample_valid, sample_ready, fifo_level  consumer side of the FIFO
module bus_dma_reader #(
  parameter int A_WIDTH    = 32,
  parameter int D_WIDTH    = 32,
  parameter int C_WIDTH    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk50MHz,
  input  logic                        reset_L,
  input  logic                        start,
  input  logic [A_WIDTH-1:0]          base_addr,
  input  logic [15:0]                 word_count,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        bus_req,
  input  logic                        bus_ack,
  input  logic [C_WIDTH-1:0]          bus_ctrl_in,
  input  logic [D_WIDTH-1:0]          bus_data_in,
  output logic [C_WIDTH-1:0]          bus_ctrl_out,
  output logic [D_WIDTH-1:0]          bus_data_out,
  output logic [D_WIDTH-1:0]          sample_data,
  output logic                        sample_valid,
  input  logic                        sample_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int P_WIDTH = $clog2(FIFO_DEPTH);
  localparam int L_WIDTH = P_WIDTH + 1;
  localparam int T_WIDTH = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, CMD, DATA, GAP, DONE} state_t;
  state_t state, state_nx;
  logic [A_WIDTH-1:0] addr;
  logic [15:0] rem;
  logic [6:0] n, beats;
  logic [T_WIDTH-1:0] idle;
  logic fifo_ok, beat, last, abort, pop;
  logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [P_WIDTH-1:0] wr_ptr, rd_ptr;
  // n stays constant for a whole tenure because rem only changes on the last beat
  always_comb begin
    n = (rem >= 16'(BURST_LEN)) ? 7'(BURST_LEN) : rem[6:0];
    // requesting only when n free slots exist reserves room for the whole burst
    fifo_ok = FIFO_DEPTH - 32'(fifo_level) >= 32'(n);
    beat = (state == DATA) && bus_ack && (bus_ctrl_in == C_WIDTH'(8'h80));
    last = beat && (beats + 7'd1 == n);
    abort = (state == DATA) && (!bus_ack || (!beat && 32'(idle) + 32'd1 >= 32'(TIMEOUT)));
    pop = sample_valid && sample_ready;
  end
  always_comb begin
    state_nx = state;
    bus_req = 1'b0;
    bus_ctrl_out = '0;
    bus_data_out = '0;
    case (state)
      IDLE: state_nx = start ? ((word_count == 16'd0) ? DONE : REQ) : IDLE;
      REQ: begin
        bus_req = fifo_ok;
        state_nx = (fifo_ok && bus_ack) ? CMD : REQ;
      end
      CMD: begin
        bus_req = 1'b1;
        bus_ctrl_out = {2'b01, (C_WIDTH-2)'(n - 7'd1)};
        bus_data_out = D_WIDTH'(addr);
        state_nx = DATA;
      end
      DATA: begin
        bus_req = 1'b1;
        state_nx = abort ? DONE : (last ? GAP : DATA);
      end
      // one cycle with bus_req low lets the arbiter rotate to another master
      GAP: state_nx = (rem != 16'd0) ? REQ : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign sample_valid = fifo_level != '0;
  assign sample_data = sample_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk50MHz or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      beats <= '0;
      idle <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        addr <= base_addr;
        rem <= word_count;
        err <= 1'b0;
      end
      if (state == CMD) begin
        beats <= '0;
        idle <= '0;
      end
      if (beat) begin
        beats <= beats + 7'd1;
        idle <= '0;
      end else if (state == DATA) idle <= idle + 1'b1;
      if (last) begin
        addr <= addr + A_WIDTH'({n, 2'b00});
        rem <= rem - 16'(n);
      end
      if (abort) err <= 1'b1;
    end
  end
  always_ff @(posedge clk50MHz or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      if (beat) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + L_WIDTH'(beat) - L_WIDTH'(pop);
    end
  end
  always_ff @(posedge clk50MHz) begin
    if (beat) mem[wr_ptr] <= bus_data_in;
  end
endmodule

// File: tb/tb_bus_dma_reader.sv
// tb_bus_dma_reader: self-checking bench with bus responder, scoreboarded consumer and command model
module tb_bus_dma_reader;
  localparam int BL = 4;
  localparam int TO = 255;
  logic clk50MHz = 1'b0;
  logic reset_L = 1'b0;
  logic start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic busy, done, err, bus_req, sample_valid;
  logic bus_ack = 1'b0;
  logic [7:0] bus_ctrl_in = '0;
  logic [31:0] bus_data_in = '0;
  logic [7:0] bus_ctrl_out;
  logic [31:0] bus_data_out, sample_data;
  logic sample_ready = 1'b0;
  logic [4:0] fifo_level;
  bus_dma_reader #(.A_WIDTH(32), .D_WIDTH(32), .C_WIDTH(8), .FIFO_DEPTH(16), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk50MHz(clk50MHz), .reset_L(reset_L), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .err(err), .bus_req(bus_req), .bus_ack(bus_ack), .bus_ctrl_in(bus_ctrl_in),
    .bus_data_in(bus_data_in), .bus_ctrl_out(bus_ctrl_out), .bus_data_out(bus_data_out),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready), .fifo_level(fifo_level)
  );
  always #10 clk50MHz = ~clk50MHz;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] exp_q[$];
  bit ready_en = 0, jitter = 0;
  int beat_limit = -1, ack_kill_at = -1;
  int beats_sent, pops, done_cnt, req_rises, cmd_cnt, last_beat_cyc, done_cyc, start_cyc, pending, m_rem;
  logic [31:0] m_addr, data_base;
  logic prev_req;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // responder, bus monitor and consumer all act on the falling edge
  initial begin
    int exp_n;
    forever begin
      @(negedge clk50MHz);
      cyc++;
      if (!reset_L) begin
        pending = 0;
        bus_ack = 1'b0;
        bus_ctrl_in = '0;
        bus_data_in = '0;
        prev_req = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (bus_req && !prev_req) req_rises++;
        prev_req = bus_req;
        if (bus_ctrl_out[7:6] != 2'b01 && (bus_ctrl_out != '0 || bus_data_out != '0))
          check("bus_idle_zero", {bus_ctrl_out, bus_data_out}, 64'd0);
        bus_ctrl_in = '0;
        bus_data_in = '0;
        bus_ack = bus_req && !(ack_kill_at >= 0 && beats_sent >= ack_kill_at);
        if (!bus_req) pending = 0;
        if (bus_ctrl_out[7:6] == 2'b01) begin
          exp_n = (m_rem < BL) ? m_rem : BL;
          check("cmd_ctrl", bus_ctrl_out, {2'b01, 6'(exp_n - 1)});
          check("cmd_addr", bus_data_out, m_addr);
          cmd_cnt++;
          pending = exp_n;
          m_addr = m_addr + 32'(4 * exp_n);
          m_rem = m_rem - exp_n;
        end else if (pending > 0 && bus_ack && (beat_limit < 0 || beats_sent < beat_limit) &&
                     (!jitter || $urandom_range(0, 2) != 0)) begin
          bus_ctrl_in = 8'h80;
          bus_data_in = data_base + 32'(beats_sent);
          exp_q.push_back(bus_data_in);
          beats_sent++;
          pending--;
          last_beat_cyc = cyc;
        end
        sample_ready = ready_en && (!jitter || $urandom_range(0, 1) == 1);
        if (sample_ready && sample_valid) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got %0h expected no word", sample_data);
          end else check("sample_data", sample_data, exp_q.pop_front());
        end
      end
    end
  end
  task automatic go(input logic [31:0] b, input int cnt, input logic [31:0] db);
    m_addr = b;
    m_rem = cnt;
    data_base = db;
    beats_sent = 0;
    pops = 0;
    done_cnt = 0;
    req_rises = 0;
    cmd_cnt = 0;
    @(negedge clk50MHz);
    start = 1'b1;
    base_addr = b;
    word_count = cnt[15:0];
    start_cyc = cyc;
    @(negedge clk50MHz);
    start = 1'b0;
  endtask
  task automatic wait_done(input int limit);
    bit ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk50MHz);
      ok = done_cnt > 0;
    end
    check("done_seen", ok, 1);
  endtask
  task automatic drain(input int limit);
    ready_en = 1;
    for (int i = 0; i < limit && (exp_q.size() != 0 || sample_valid); i++) @(negedge clk50MHz);
    check("drain_level", fifo_level, 0);
    check("drain_sb_empty", exp_q.size(), 0);
  endtask
  typedef struct {
    logic [31:0] base;
    int cnt;
    bit jit;
    int cmds;
    int rises;
  } vec_t;
  vec_t vecs[5];
  initial begin
    bit ok;
    vecs[0] = '{32'h100, 4, 0, 1, 1};
    vecs[1] = '{32'h100, 10, 0, 3, 3};
    vecs[2] = '{32'hFFFF_FFF8, 6, 0, 2, 2};
    vecs[3] = '{32'h2000, 9, 1, 3, 3};
    vecs[4] = '{32'h40, 1, 0, 1, 1};
    repeat (3) @(negedge clk50MHz);
    check("rst_status", {busy, done, err, bus_req, sample_valid, fifo_level}, 0);
    check("rst_bus", {bus_ctrl_out, bus_data_out}, 0);
    check("rst_sample", sample_data, 0);
    #2 reset_L = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ready_en = 1;
      jitter = vecs[i].jit;
      go(vecs[i].base, vecs[i].cnt, 32'hA + 32'(i * 'h100));
      wait_done(2000);
      repeat (3) @(negedge clk50MHz);
      check("vec_done_once", done_cnt, 1);
      check("vec_err", err, 0);
      check("vec_busy", busy, 0);
      check("vec_cmds", cmd_cnt, vecs[i].cmds);
      check("vec_req_rises", req_rises, vecs[i].rises);
      drain(200);
      check("vec_pops", pops, vecs[i].cnt);
    end
    jitter = 0;
    go(32'h300, 0, 32'h0);
    repeat (4) @(negedge clk50MHz);
    check("zero_done_once", done_cnt, 1);
    check("zero_latency", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);
    check("zero_no_req", req_rises, 0);
    check("zero_busy", busy, 0);
    ready_en = 0;
    go(32'h500, 20, 32'h5000);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk50MHz);
      ok = fifo_level == 5'd16;
    end
    check("bp_full", ok, 1);
    repeat (20) @(negedge clk50MHz);
    check("bp_req_low", bus_req, 0);
    check("bp_level", fifo_level, 16);
    check("bp_busy", busy, 1);
    check("bp_beats", beats_sent, 16);
    ready_en = 1;
    wait_done(500);
    drain(200);
    check("bp_pops", pops, 20);
    check("bp_cmds", cmd_cnt, 5);
    check("bp_err", err, 0);
    ready_en = 0;
    beat_limit = 2;
    go(32'h600, 4, 32'h6000);
    wait_done(TO + 50);
    repeat (2) @(negedge clk50MHz);
    check("to_err", err, 1);
    check("to_level", fifo_level, 2);
    check("to_done_once", done_cnt, 1);
    check("to_delay", done_cyc - last_beat_cyc, TO + 1);
    beat_limit = -1;
    drain(50);
    check("to_pops", pops, 2);
    ready_en = 0;
    ack_kill_at = 2;
    go(32'h700, 4, 32'h7000);
    check("ack_err_cleared", err, 0);
    wait_done(100);
    repeat (2) @(negedge clk50MHz);
    check("ack_err", err, 1);
    check("ack_level", fifo_level, 2);
    ack_kill_at = -1;
    drain(50);
    check("ack_pops", pops, 2);
    ready_en = 0;
    go(32'h800, 8, 32'h8000);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk50MHz);
      ok = beats_sent >= 2;
    end
    check("rst_mid_data", ok, 1);
    #2 reset_L = 1'b0;
    #1;
    check("arst_status", {busy, done, err, bus_req, sample_valid, fifo_level}, 0);
    check("arst_bus", {bus_ctrl_out, bus_data_out}, 0);
    check("arst_sample", sample_data, 0);
    exp_q.delete();
    repeat (2) @(negedge clk50MHz);
    #2 reset_L = 1'b1;
    ready_en = 1;
    go(32'h900, 4, 32'h9000);
    wait_done(200);
    drain(100);
    check("post_rst_err", err, 0);
    check("post_rst_cmds", cmd_cnt, 1);
    check("post_rst_pops", pops, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_dma_reader.md
Name: bus_dma_reader

Overview:
- Bus initiator that fetches a block of consecutive 32-bit words from RAM over the shared arbitrated bus and buffers them for a streaming consumer. First consumer is the audio copper's sample path.
- It is the requesting end of the bus protocol that the SRAM controller answers. It occupies one BusController master slot, driving req/ctrl/data and receiving ack/ctrl/data.
- Internal FIFO decouples bus bursts from the consumer's rate.

Parameters:
- A_WIDTH, 32, address width driven in the command beat
- D_WIDTH, 32, bus data and sample width
- C_WIDTH, 8, bus control width
- FIFO_DEPTH, 16, sample FIFO entries (power of two, ≥ BURST_LEN)
- BURST_LEN, 4, max words per bus tenure (1..64)
- TIMEOUT, 255, max idle cycles in DATA before abort

Ports:
- clk50MHz  in  1  system clock
- reset_L  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begin transfer
- base_addr  in  A_WIDTH  byte address of first word (word aligned)
- word_count  in  16  words to fetch
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- err  out  1  sticky abort flag, cleared by next accepted start
- bus_req  out  1  to BusController req slot
- bus_ack  in  1  grant from BusController
- bus_ctrl_in  in  C_WIDTH  arbitrated control
- bus_data_in  in  D_WIDTH  arbitrated data
- bus_ctrl_out  out  C_WIDTH  control driven while granted
- bus_data_out  out  D_WIDTH  data driven while granted
- sample_data  out  D_WIDTH  FIFO head
- sample_valid  out  1  FIFO non-empty
- sample_ready  in  1  consumer pop
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters and address cleared. Reset is asynchronous and may abort any state.
- Ctrl encoding:
  - 8'h00 idle.
  - Read command: {2'b01, n-1}, with the address on bus_data_out in the same cycle.
  - Responder data beat: bus_ctrl_in == 8'h80; one word per such cycle; beats may be non-consecutive.
- bus_ctrl_out and bus_data_out are 0 in every state except CMD.
- IDLE:
  - busy=0; start with busy=0 latches addr=base_addr and rem=word_count, and clears err.
  - rem==0 → DONE; otherwise → REQ.
  - start while busy is ignored.
- REQ:
  - busy=1; n = min(BURST_LEN, rem).
  - bus_req asserts only when FIFO_DEPTH − fifo_level ≥ n, which reserves space and makes overflow impossible.
  - bus_ack=1 while bus_req=1 → CMD.
- CMD: exactly one cycle; drive command and addr; bus_req held → DATA.
- DATA:
  - bus_req held.
  - Each 8'h80 cycle pushes bus_data_in and increments beat count.
  - After the n-th beat: addr += 4·n, rem −= n. Next cycle bus_req=0 for ≥1 cycle to let the arbiter rotate; then → REQ if rem>0, else → DONE.
  - If bus_ack drops before the n-th beat, or TIMEOUT consecutive cycles pass with no beat: err=1, bus_req=0, → DONE. Words already pushed remain in the FIFO.
- DONE: done=1 for one cycle, busy=0 next cycle → IDLE.
- FIFO:
  - Show-ahead; pop on sample_valid & sample_ready.
  - Push and pop in the same cycle: level unchanged.
  - Pop when empty: no effect.
  - Contents persist across DONE and start; only reset clears it.
  - Pointers wrap modulo FIFO_DEPTH.
- Address arithmetic: modulo 2^A_WIDTH, so wrap past the top is silent. rem never underflows.

Test Plan:
- start, base 0x100, count 4, responder gives 4 beats 0xA..0xD back-to-back after CMD → one CMD with ctrl 8'h43 and data 0x100; FIFO holds A,B,C,D in order; done pulses once; err=0.
- count 10, BURST_LEN 4 → three tenures: ctrl 8'h43 @0x100, 8'h43 @0x110, 8'h41 @0x120; bus_req low ≥1 cycle between tenures.
- count 20, sample_ready=0 → after 16 words bus_req stays low with level=16. Raise ready → remaining 4 words fetched; no word lost or duplicated.
- count 0 → done pulses 2 cycles after start; bus_req never asserts.
- Responder sends 2 of 4 beats, then silence → err=1 after TIMEOUT idle cycles; done pulses; FIFO level 2. Repeat with bus_ack dropped mid-burst → same abort.
- reset_L low mid-DATA → all outputs 0 immediately; FIFO empty; a new start works normally.
